// File: rtl/shreg_ctrl_pkg.sv
// Shared defines (logic levels, MODO codes, state encodings, bench clock constants)
// and the shreg_ctrl package with the FSM state type.
`ifndef SHREG_DEFS_VH
`define SHREG_DEFS_VH
`define LOW         1'b0
`define HIGH        1'b1
`define ENABLE      1'b1
`define MODO_00     2'b00
`define MODO_01     2'b01
`define MODO_10     2'b10
`define MODO_11     2'b11
`define STATE_IDLE  3'd0
`define STATE_LOAD  3'd1
`define STATE_SHIFT 3'd2
`define STATE_WAITQ 3'd3
`define STATE_DONE  3'd4
`define CLK_PERIOD  10
`define CLK_HALF    5
`endif

package shreg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = `STATE_IDLE,
    ST_LOAD  = `STATE_LOAD,
    ST_SHIFT = `STATE_SHIFT,
    ST_WAITQ = `STATE_WAITQ,
    ST_DONE  = `STATE_DONE
  } state_t;

endpackage

// File: rtl/shreg_ctrl_cnt.sv
// Loadable shift-count down-counter; loads clamp to WIDTH, flags zero and last.
module shreg_ctrl_cnt #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= (load_val > MAX_CNT) ? MAX_CNT : load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign zero = (count_reg == '0);
  assign last = (count_reg == CNT_W'(1));

endmodule

// File: rtl/shreg_ctrl.sv
// Sequencer for the 4-bit universal shift register: load, shift N times, return bits and Q.
// Optional rotate mode (S_IN fed from S_OUT) is enabled by defining SHREG_CTRL_ROTATE_EN.
module shreg_ctrl
  import shreg_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_dir,
  input  logic [CNT_W-1:0] req_count,
  input  logic             req_fill,
`ifdef SHREG_CTRL_ROTATE_EN
  input  logic             req_rot,
`endif
  output logic             enb,
  output logic             dir,
  output logic             s_in,
  output logic [1:0]       modo,
  output logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  input  logic             s_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_bits,
  output logic [WIDTH-1:0] rsp_q
);

  state_t           state_reg;
  logic             s_in_reg;
  logic [CNT_W-1:0] bit_idx_reg;
  logic [WIDTH-1:0] cap_mask;
  logic             accept;
  logic             cnt_zero;
  logic             cnt_last;

  assign accept = (state_reg == ST_IDLE) && req_valid;

  shreg_ctrl_cnt #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .load_val(req_count),
    .dec     (state_reg == ST_SHIFT),
    .zero    (cnt_zero),
    .last    (cnt_last)
  );

  // One-hot select of the RSP_BITS slot that receives the current S_OUT sample.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cap
    assign cap_mask[gi] = (bit_idx_reg == CNT_W'(gi));
  end

`ifdef SHREG_CTRL_ROTATE_EN
  logic rot_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_reg <= 1'b0;
    end else if (accept) begin
      rot_reg <= req_rot;
    end
  end

  assign s_in = (rot_reg && (state_reg == ST_SHIFT)) ? s_out : s_in_reg;
`else
  assign s_in = s_in_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      req_ready   <= 1'b1;
      enb         <= ~`ENABLE;
      dir         <= `LOW;
      s_in_reg    <= `LOW;
      modo        <= `MODO_00;
      d           <= '0;
      rsp_valid   <= 1'b0;
      rsp_bits    <= '0;
      rsp_q       <= '0;
      bit_idx_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            enb         <= `ENABLE;
            modo        <= `MODO_10;
            d           <= req_data;
            dir         <= req_dir;
            s_in_reg    <= req_fill;
            bit_idx_reg <= '0;
            state_reg   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          modo <= `MODO_00;
          if (!cnt_zero) begin
            state_reg <= ST_SHIFT;
          end else begin
            enb       <= ~`ENABLE;
            state_reg <= ST_WAITQ;
          end
        end
        ST_SHIFT: begin
          // RSP_BITS was cleared at the previous handshake, so OR-ing is enough.
          rsp_bits    <= rsp_bits | (s_out ? cap_mask : '0);
          bit_idx_reg <= bit_idx_reg + CNT_W'(1);
          if (cnt_last) begin
            enb       <= ~`ENABLE;
            state_reg <= ST_WAITQ;
          end
        end
        ST_WAITQ: begin
          rsp_q     <= q;
          rsp_valid <= 1'b1;
          state_reg <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_bits  <= '0;
            req_ready <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          req_ready <= 1'b1;
          enb       <= ~`ENABLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shreg_ctrl.sv
// Bench for shreg_ctrl: attached shift-register model, cycle-level reference model,
// per-cycle compare process and directed commands with literal expectations.
module tb_shreg_ctrl;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_data = 4'd0;
  logic       req_dir = 1'b0;
  logic [2:0] req_count = 3'd0;
  logic       req_fill = 1'b0;
  logic       req_rot = 1'b0;
  logic       enb, dir, s_in;
  logic [1:0] modo;
  logic [3:0] d;
  logic [3:0] q;
  logic       s_out;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_bits, rsp_q;

  int n_checks = 0;
  int n_fail = 0;

  always #HALF clk = ~clk;

  shreg_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_dir(req_dir), .req_count(req_count), .req_fill(req_fill),
`ifdef SHREG_CTRL_ROTATE_EN
    .req_rot(req_rot),
`endif
    .enb(enb), .dir(dir), .s_in(s_in), .modo(modo), .d(d),
    .q(q), .s_out(s_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_bits(rsp_bits), .rsp_q(rsp_q)
  );

  // Universal shift register: left moves toward MSB (S_OUT=Q[3]), right toward LSB (S_OUT=Q[0]).
  assign s_out = dir ? q[0] : q[3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 4'd0;
    else if (enb) begin
      if (modo == 2'b10) q <= d;
      else if (modo == 2'b00) q <= dir ? {s_in, q[3:1]} : {q[2:0], s_in};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of a command computed directly from the shift rules: {bits, final q}.
  function automatic logic [7:0] predict(input logic [3:0] data, input logic dr,
                                         input int n, input logic fill, input logic rot);
    logic [3:0] qq = data;
    logic [3:0] bits = 4'd0;
    logic so, si;
    for (int i = 0; i < n; i++) begin
      so = dr ? qq[0] : qq[3];
      bits[i] = so;
      si = rot ? so : fill;
      qq = dr ? {si, qq[3:1]} : {qq[2:0], si};
    end
    return {bits, qq};
  endfunction

  // Reference model: m_k counts clock edges since the accept edge.
  logic       m_busy = 1'b0;
  int         m_k = 0;
  int         m_n = 0;
  logic [3:0] m_data, m_eq, m_eb;
  logic       m_dir, m_fill, m_rot;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        logic [7:0] r;
        int n;
        logic rot;
        n = (req_count > 3'd4) ? 4 : int'(req_count);
`ifdef SHREG_CTRL_ROTATE_EN
        rot = req_rot;
`else
        rot = 1'b0;
`endif
        r = predict(req_data, req_dir, n, req_fill, rot);
        m_busy <= 1'b1;
        m_k    <= 0;
        m_n    <= n;
        m_data <= req_data;
        m_dir  <= req_dir;
        m_fill <= req_fill;
        m_rot  <= rot;
        m_eb   <= r[7:4];
        m_eq   <= r[3:0];
      end
    end else if ((m_k >= m_n + 2) && rsp_ready) begin
      m_busy <= 1'b0;
    end else if (m_k < 1000) begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", req_ready, 1);
      chk("rst_enb", enb, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_modo", modo, 0);
      chk("rst_bits", rsp_bits, 0);
    end else if (!m_busy) begin
      chk("idle_ready", req_ready, 1);
      chk("idle_enb", enb, 0);
      chk("idle_valid", rsp_valid, 0);
      chk("idle_bits", rsp_bits, 0);
    end else begin
      chk("busy_ready", req_ready, 0);
      if (m_k == 0) begin
        chk("load_enb", enb, 1);
        chk("load_modo", modo, 2'b10);
        chk("load_d", d, m_data);
        chk("load_valid", rsp_valid, 0);
      end else if (m_k <= m_n) begin
        chk("shift_enb", enb, 1);
        chk("shift_modo", modo, 2'b00);
        chk("shift_dir", dir, m_dir);
        chk("shift_sin", s_in, m_rot ? s_out : m_fill);
        chk("shift_valid", rsp_valid, 0);
      end else if (m_k == m_n + 1) begin
        chk("waitq_enb", enb, 0);
        chk("waitq_valid", rsp_valid, 0);
      end else begin
        chk("done_enb", enb, 0);
        chk("done_valid", rsp_valid, 1);
        chk("done_bits", rsp_bits, m_eb);
        chk("done_q", rsp_q, m_eq);
      end
    end
  end

  task automatic run_cmd(input logic [3:0] data, input logic dr, input logic [2:0] cnt,
                         input logic fill, input logic rot,
                         input logic [3:0] lit_q, input logic [3:0] lit_bits,
                         input int lit_lat, input int lit_shifts,
                         input int hold, input logic pulse);
    int lat, shifts;
    @(negedge clk); #1;
    req_data = data; req_dir = dr; req_count = cnt; req_fill = fill; req_rot = rot;
    req_valid = 1'b1;
    @(posedge clk); #1;
    chk("lit_load_modo", modo, 2'b10);
    req_valid = 1'b0;
    req_data = ~data; req_dir = ~dr; req_fill = ~fill;
    lat = 0; shifts = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (enb && modo == 2'b00) shifts++;
    end while (!rsp_valid && lat < 40);
    chk("lit_latency", lat, lit_lat);
    chk("lit_shifts", shifts, lit_shifts);
    chk("lit_rsp_q", rsp_q, lit_q);
    chk("lit_rsp_bits", rsp_bits, lit_bits);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      req_valid = pulse & i[0];
      req_data = 4'(i);
      @(posedge clk); #1;
      chk("hold_ready", req_ready, 0);
      chk("hold_q", rsp_q, lit_q);
    end
    @(negedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = pulse;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("lit_idle_ready", req_ready, 1);
    chk("lit_idle_valid", rsp_valid, 0);
    $display("cmd data=%b dir=%0d count=%0d fill=%0d rot=%0d -> rsp_q=%b rsp_bits=%b latency=%0d shifts=%0d",
             data, dr, cnt, fill, rot, rsp_q, lit_bits, lat, shifts);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_ready", req_ready, 1);
    chk("lit_rst_rsp_q", rsp_q, 0);
    chk("lit_rst_d", d, 0);
    chk("lit_rst_dir", dir, 0);
    chk("lit_rst_sin", s_in, 0);
    rst_n = 1'b1;

    run_cmd(4'b0001, 1'b0, 3'd3, 1'b0, 1'b0, 4'b1000, 4'b0000, 5, 3, 0, 1'b0);
    run_cmd(4'b1011, 1'b1, 3'd4, 1'b1, 1'b0, 4'b1111, 4'b1011, 6, 4, 0, 1'b0);
    run_cmd(4'b0110, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0110, 4'b0000, 2, 0, 0, 1'b0);
    run_cmd(4'b1100, 1'b0, 3'd7, 1'b1, 1'b0, 4'b1111, 4'b0011, 6, 4, 0, 1'b0);
    run_cmd(4'b0101, 1'b1, 3'd2, 1'b0, 1'b0, 4'b0001, 4'b0001, 4, 2, 10, 1'b1);

    // Abort during the second SHIFT cycle.
    @(negedge clk); #1;
    req_data = 4'b1111; req_dir = 1'b0; req_count = 3'd4; req_fill = 1'b0; req_rot = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", req_ready, 1);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_enb", enb, 0);
    chk("abort_modo", modo, 2'b00);
    chk("abort_d", d, 0);
    chk("abort_bits", rsp_bits, 0);
    $display("reset during shift -> req_ready=%0d rsp_valid=%0d enb=%0d", req_ready, rsp_valid, enb);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_cmd(4'b1010, 1'b0, 3'd1, 1'b1, 1'b0, 4'b0101, 4'b0001, 3, 1, 0, 1'b0);
`ifdef SHREG_CTRL_ROTATE_EN
    run_cmd(4'b1001, 1'b0, 3'd4, 1'b0, 1'b1, 4'b1001, 4'b1001, 6, 4, 0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
